// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential restoring divider.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. It produces one
// quotient bit per clock, most significant bit first. The start/busy
// handshake is the same as the shift-add multiplier's, so one controller can
// drive either unit.
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous reset, active low (clears all results and state)
//   start_i  start request; sampled only while idle
//   a_bi     dividend (2*WIDTH bits), captured on the accepting edge
//   b_bi     divisor (WIDTH bits), captured on the accepting edge
//   q_bo     quotient (registered); all ones after a divide-by-zero
//   r_bo     remainder (registered); zero after a divide-by-zero
//   busy_o   high while an operation is in flight
//   dz_o     high when the last result was a divide-by-zero
//
// Timing: counting the accepting edge as edge 1, the results update and
// busy_o falls on edge 2*WIDTH+2. For a zero divisor this happens on edge 2.
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2*WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    output logic [2*WIDTH-1:0]   q_bo,
    output logic [WIDTH-1:0]     r_bo,
    output logic                 busy_o,
    output logic                 dz_o
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORK = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;     // dividend shift register
    logic [WIDTH-1:0]     dvs_q, dvs_d;     // captured divisor
    // The partial remainder is always below the divisor once a step completes.
    // Its top bit is therefore always zero, so only WIDTH bits are stored. The
    // trial subtraction below is still done at WIDTH+1 bits.
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0]   quo_q, quo_d;     // quotient bits are collected here
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic                 busy_q, busy_d;
    logic                 dz_q, dz_d;

    // Bring down the next dividend bit, then try to subtract the divisor.
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;

    assign shifted = {rem_q, dvd_q[2*WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dvd_d   = a_bi;
                    dvs_d   = b_bi;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    // A zero divisor skips the shift loop entirely.
                    state_d = (b_bi == '0) ? S_END : S_WORK;
                end
            end

            S_WORK: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[2*WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[2*WIDTH-2:0], 1'b0};
                end
                dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_END;
                end
            end

            S_END: begin
                if (dvs_q == '0) begin
                    q_d  = '1;
                    r_d  = '0;
                    dz_d = 1'b1;
                end else begin
                    q_d  = quo_q;
                    r_d  = rem_q;
                    dz_d = 1'b0;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign q_bo   = q_q;
    assign r_bo   = r_q;
    assign busy_o = busy_q;
    assign dz_o   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq (WIDTH = 8).
//
// A behavioural model computes quotient and remainder with plain / and %.
// It knows when the results must appear and when busy must be high. A compare
// process checks all four outputs against the model on every falling clock
// edge. Directed operations also check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_div_seq;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 1;   // edges after the start edge (normal case)

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [2*W-1:0]   a_bi;
    logic [W-1:0]     b_bi;
    logic [2*W-1:0]   q_bo;
    logic [W-1:0]     r_bo;
    logic             busy_o;
    logic             dz_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .busy_o  (busy_o),
        .dz_o    (dz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2*W-1:0] m_q, p_q;
    logic [W-1:0]   m_r, p_r;
    logic           m_dz, p_dz, m_busy;
    int             m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_q    = p_q;
                m_r    = p_r;
                m_dz   = p_dz;
            end
        end else if (start_i) begin
            if (b_bi == 0) begin
                p_q = '1; p_r = '0; p_dz = 1'b1; m_left = 1;
            end else begin
                p_q = a_bi / {8'd0, b_bi};
                p_r = W'(a_bi % {8'd0, b_bi});
                p_dz = 1'b0; m_left = LAT;
            end
            m_busy = 1'b1;
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_q",    32'(q_bo),   32'(m_q));
            chk("cyc_r",    32'(r_bo),   32'(m_r));
            chk("cyc_dz",   32'(dz_o),   32'(m_dz));
            chk("cyc_busy", 32'(busy_o), 32'(m_busy));
        end
    end

    // Must be called at a falling edge while the DUT is idle. It starts one
    // operation and returns at the falling edge where busy has dropped.
    int busy_cycles;
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
        a_bi = a; b_bi = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_bi = 16'($urandom);          // inputs are free to change after the start edge
        b_bi = 8'($urandom);
        busy_cycles = 0;
        while (busy_o === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 200) begin
            errors++;
            $display("FAIL timeout waiting for busy to fall a=%0h b=%0h", a, b);
        end
        if (b != 0) begin
            chk("ident", 32'(q_bo) * 32'(b) + 32'(r_bo), 32'(a));
            chk("r_lt_b", 32'(r_bo < b), 32'd1);
        end
        $display("op a=%04h b=%02h -> q=%04h r=%02h dz=%0b busy_cycles=%0d", a, b, q_bo, r_bo, dz_o, busy_cycles);
    endtask

    task automatic expect_res(input string tag, input logic [15:0] q, input logic [7:0] r, input logic dz);
        chk({tag, "_q"},  32'(q_bo), 32'(q));
        chk({tag, "_r"},  32'(r_bo), 32'(r));
        chk({tag, "_dz"}, 32'(dz_o), 32'(dz));
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; a_bi = '0; b_bi = '0;
        repeat (3) @(negedge clk);
        expect_res("reset", 16'h0000, 8'h00, 1'b0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic divide and busy duration
        run_op(16'd1000, 8'd7);
        expect_res("t1", 16'h008E, 8'h06, 1'b0);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'(LAT));

        // 2: extremes, issued back to back
        run_op(16'hFFFF, 8'h01);
        expect_res("t2a", 16'hFFFF, 8'h00, 1'b0);
        run_op(16'hFFFF, 8'hFF);
        expect_res("t2b", 16'h0101, 8'h00, 1'b0);
        chk("t2b_busy_cycles", 32'(busy_cycles), 32'(LAT));

        // 3: dividend smaller than divisor, and zero dividend
        run_op(16'd100, 8'd200);
        expect_res("t3a", 16'h0000, 8'h64, 1'b0);
        run_op(16'd0, 8'd5);
        expect_res("t3b", 16'h0000, 8'h00, 1'b0);

        // 4: divide by zero, then a valid divide clears dz
        run_op(16'h1234, 8'h00);
        expect_res("t4dz", 16'hFFFF, 8'h00, 1'b1);
        chk("t4_busy_cycles", 32'(busy_cycles), 32'd1);
        run_op(16'd200, 8'd9);
        expect_res("t4clr", 16'd22, 8'd2, 1'b0);

        // 5: start pulse while busy is ignored
        a_bi = 16'd1000; b_bi = 8'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        a_bi = 16'd50; b_bi = 8'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        busy_cycles = 0;
        while (busy_o === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
        expect_res("t5", 16'd142, 8'd6, 1'b0);
        @(negedge clk);
        chk("t5_idle", 32'(busy_o), 32'd0);

        // 6: asynchronous reset in the middle of an operation
        a_bi = 16'd1000; b_bi = 8'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_res("t6rst", 16'h0000, 8'h00, 1'b0);
        chk("t6rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd200, 8'd9);
        expect_res("t6", 16'd22, 8'd2, 1'b0);

        // 7: random sweep with nonzero divisors
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
